// File: rtl/vending_machine_multi.sv
// Multi-coin, multi-product vending controller.
// Credits coins of any denomination, dispenses one of NUM_ITEMS products
// at its own price, returns change, refunds on cancel or after an idle
// timeout. Every response output is registered, so pulses appear one
// cycle after the inputs that caused them are sampled.
module vending_machine_multi #(
  parameter int                            CREDIT_W  = 8,
  parameter int                            NUM_ITEMS = 4,
  parameter int                            SEL_W     = 2,
  parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES    = {8'd10, 8'd7, 8'd5, 8'd3},
  parameter int                            TIMEOUT   = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                coin_valid_i,
  input  logic [CREDIT_W-1:0] coin_value_i,
  input  logic                select_valid_i,
  input  logic [SEL_W-1:0]    select_i,
  input  logic                cancel_i,
  output logic                valid_o,
  output logic [SEL_W-1:0]    item_o,
  output logic                change_valid_o,
  output logic [CREDIT_W-1:0] change_o,
  output logic                coin_reject_o,
  output logic                deny_o,
  output logic [CREDIT_W-1:0] credit_o
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TMR_W-1:0]    timer_q, timer_d;

  logic                valid_q, valid_d;
  logic [SEL_W-1:0]    item_q, item_d;
  logic                change_valid_q, change_valid_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                coin_reject_q, coin_reject_d;
  logic                deny_q, deny_d;

  logic [CREDIT_W-1:0] price;
  logic                selInRange;
  logic [CREDIT_W:0]   coinSum;
  logic                coinPresent;
  logic                accepted;
  logic                coinTaken;

  // Look up the price of the requested item; indices past the last item are flagged out of range.
  always_comb begin
    price      = '0;
    selInRange = 1'b0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (select_i == SEL_W'(i)) begin
        price      = PRICES[i*CREDIT_W +: CREDIT_W];
        selInRange = 1'b1;
      end
    end
  end

  // Extra sum bit detects overflow so the accumulator can refuse a coin instead of wrapping.
  assign coinSum     = {1'b0, credit_q} + {1'b0, coin_value_i};
  assign coinPresent = coin_valid_i && (coin_value_i != '0);

  // Next-state and next-output logic: cancel beats select beats coin; a coin is only refused when something else consumed the cycle.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    timer_d        = timer_q;
    valid_d        = 1'b0;
    item_d         = '0;
    change_valid_d = 1'b0;
    change_d       = '0;
    coin_reject_d  = 1'b0;
    deny_d         = 1'b0;
    accepted       = 1'b0;
    coinTaken      = 1'b0;

    case (state_q)
      DISPENSE: begin
        state_d       = IDLE;
        credit_d      = '0;
        timer_d       = '0;
        coin_reject_d = coinPresent;
      end

      default: begin
        if (cancel_i && (credit_q != '0)) begin
          accepted       = 1'b1;
          state_d        = DISPENSE;
          change_valid_d = 1'b1;
          change_d       = credit_q;
          credit_d       = '0;
          timer_d        = '0;
        end else if (select_valid_i) begin
          if (selInRange && (credit_q >= price)) begin
            accepted       = 1'b1;
            state_d        = DISPENSE;
            valid_d        = 1'b1;
            item_d         = select_i;
            change_d       = credit_q - price;
            change_valid_d = (credit_q != price);
            credit_d       = '0;
            timer_d        = '0;
          end else begin
            deny_d = 1'b1;
          end
        end

        if (accepted) begin
          coin_reject_d = coinPresent;
        end else begin
          if (coinPresent) begin
            if (!coinSum[CREDIT_W]) begin
              credit_d  = coinSum[CREDIT_W-1:0];
              coinTaken = 1'b1;
            end else begin
              coin_reject_d = 1'b1;
            end
          end

          if (coinTaken) begin
            timer_d = '0;
            state_d = COLLECT;
          end else if (state_q == COLLECT) begin
            if (timer_q == TMR_W'(TIMEOUT - 1)) begin
              state_d        = DISPENSE;
              change_valid_d = 1'b1;
              change_d       = credit_q;
              credit_d       = '0;
              timer_d        = '0;
            end else begin
              timer_d = timer_q + TMR_W'(1);
            end
          end
        end
      end
    endcase
  end

  // State, credit accumulator and idle timer; reset discards any credit without refunding it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      credit_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      timer_q  <= timer_d;
    end
  end

  // Registered response pulses; reset drops any pulse that is currently showing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q        <= 1'b0;
      item_q         <= '0;
      change_valid_q <= 1'b0;
      change_q       <= '0;
      coin_reject_q  <= 1'b0;
      deny_q         <= 1'b0;
    end else begin
      valid_q        <= valid_d;
      item_q         <= item_d;
      change_valid_q <= change_valid_d;
      change_q       <= change_d;
      coin_reject_q  <= coin_reject_d;
      deny_q         <= deny_d;
    end
  end

  assign valid_o        = valid_q;
  assign item_o         = item_q;
  assign change_valid_o = change_valid_q;
  assign change_o       = change_q;
  assign coin_reject_o  = coin_reject_q;
  assign deny_o         = deny_q;
  assign credit_o       = credit_q;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Directed bench for vending_machine_multi: a table of single-cycle vectors
// plus hand-written sequences for out-of-range select, timeout and async reset.
module tb_vending_machine_multi;

  typedef struct packed {
    logic       cv;
    logic [7:0] cval;
    logic       sv;
    logic [1:0] sel;
    logic       cancel;
  } in_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] item;
    logic       cv;
    logic [7:0] change;
    logic       rej;
    logic       deny;
    logic [7:0] credit;
  } out_t;

  typedef struct packed {
    in_t  stim;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;

  logic       aCoinValid = 1'b0, bCoinValid = 1'b0;
  logic [7:0] aCoinValue = '0,   bCoinValue = '0;
  logic       aSelValid  = 1'b0, bSelValid  = 1'b0;
  logic [1:0] aSel       = '0,   bSel       = '0;
  logic       aCancel    = 1'b0, bCancel    = 1'b0;

  logic       aValid, bValid, aChgValid, bChgValid, aRej, bRej, aDeny, bDeny;
  logic [1:0] aItem, bItem;
  logic [7:0] aChange, bChange, aCredit, bCredit;

  int testsRun    = 0;
  int testsFailed = 0;

  vec_t vecs[25];

  always #5 clk = ~clk;

  vending_machine_multi dutA (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .coin_valid_i   (aCoinValid),
    .coin_value_i   (aCoinValue),
    .select_valid_i (aSelValid),
    .select_i       (aSel),
    .cancel_i       (aCancel),
    .valid_o        (aValid),
    .item_o         (aItem),
    .change_valid_o (aChgValid),
    .change_o       (aChange),
    .coin_reject_o  (aRej),
    .deny_o         (aDeny),
    .credit_o       (aCredit)
  );

  vending_machine_multi #(
    .NUM_ITEMS (3),
    .SEL_W     (2),
    .PRICES    ({8'd7, 8'd5, 8'd3})
  ) dutB (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .coin_valid_i   (bCoinValid),
    .coin_value_i   (bCoinValue),
    .select_valid_i (bSelValid),
    .select_i       (bSel),
    .cancel_i       (bCancel),
    .valid_o        (bValid),
    .item_o         (bItem),
    .change_valid_o (bChgValid),
    .change_o       (bChange),
    .coin_reject_o  (bRej),
    .deny_o         (bDeny),
    .credit_o       (bCredit)
  );

  function automatic in_t mkIn(int cv, int cval, int sv, int sel, int cancel);
    in_t s;
    s.cv     = cv[0];
    s.cval   = cval[7:0];
    s.sv     = sv[0];
    s.sel    = sel[1:0];
    s.cancel = cancel[0];
    return s;
  endfunction

  function automatic out_t mkOut(int v, int item, int cv, int chg, int rej, int deny, int credit);
    out_t o;
    o.valid  = v[0];
    o.item   = item[1:0];
    o.cv     = cv[0];
    o.change = chg[7:0];
    o.rej    = rej[0];
    o.deny   = deny[0];
    o.credit = credit[7:0];
    return o;
  endfunction

  function automatic vec_t mkVec(in_t s, out_t e);
    vec_t v;
    v.stim = s;
    v.exp  = e;
    return v;
  endfunction

  function automatic out_t sampleA();
    return mkOut(int'(aValid), int'(aItem), int'(aChgValid), int'(aChange),
                 int'(aRej), int'(aDeny), int'(aCredit));
  endfunction

  function automatic out_t sampleB();
    return mkOut(int'(bValid), int'(bItem), int'(bChgValid), int'(bChange),
                 int'(bRej), int'(bDeny), int'(bCredit));
  endfunction

  task automatic applyStimulus(input in_t s, input bit toB);
    if (toB) begin
      bCoinValid = s.cv;
      bCoinValue = s.cval;
      bSelValid  = s.sv;
      bSel       = s.sel;
      bCancel    = s.cancel;
    end else begin
      aCoinValid = s.cv;
      aCoinValue = s.cval;
      aSelValid  = s.sv;
      aSel       = s.sel;
      aCancel    = s.cancel;
    end
  endtask

  task automatic checkOutput(input string name, input out_t got, input out_t exp);
    out_t g;
    g = got;
    if (!exp.valid) g.item   = exp.item;
    if (!exp.cv)    g.change = exp.change;
    testsRun++;
    if (g !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got valid=%0b item=%0d cv=%0b change=%0d rej=%0b deny=%0b credit=%0d, required valid=%0b item=%0d cv=%0b change=%0d rej=%0b deny=%0b credit=%0d",
               name, got.valid, got.item, got.cv, got.change, got.rej, got.deny, got.credit,
               exp.valid, exp.item, exp.cv, exp.change, exp.rej, exp.deny, exp.credit);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // inputs: cv, cval, sv, sel, cancel ; expected: valid, item, cv, change, rej, deny, credit
    vecs[0]  = mkVec(mkIn(1, 1, 0, 0, 0),   mkOut(0, 0, 0, 0,   0, 0, 1));
    vecs[1]  = mkVec(mkIn(1, 1, 0, 0, 0),   mkOut(0, 0, 0, 0,   0, 0, 2));
    vecs[2]  = mkVec(mkIn(1, 1, 0, 0, 0),   mkOut(0, 0, 0, 0,   0, 0, 3));
    vecs[3]  = mkVec(mkIn(1, 1, 0, 0, 0),   mkOut(0, 0, 0, 0,   0, 0, 4));
    vecs[4]  = mkVec(mkIn(0, 0, 1, 0, 0),   mkOut(1, 0, 1, 1,   0, 0, 0));
    vecs[5]  = mkVec(mkIn(0, 0, 0, 0, 0),   mkOut(0, 0, 0, 0,   0, 0, 0));
    vecs[6]  = mkVec(mkIn(1, 5, 0, 0, 0),   mkOut(0, 0, 0, 0,   0, 0, 5));
    vecs[7]  = mkVec(mkIn(1, 5, 0, 0, 0),   mkOut(0, 0, 0, 0,   0, 0, 10));
    vecs[8]  = mkVec(mkIn(0, 0, 1, 3, 0),   mkOut(1, 3, 0, 0,   0, 0, 0));
    vecs[9]  = mkVec(mkIn(0, 0, 0, 0, 0),   mkOut(0, 0, 0, 0,   0, 0, 0));
    vecs[10] = mkVec(mkIn(1, 4, 0, 0, 0),   mkOut(0, 0, 0, 0,   0, 0, 4));
    vecs[11] = mkVec(mkIn(0, 0, 1, 2, 0),   mkOut(0, 0, 0, 0,   0, 1, 4));
    vecs[12] = mkVec(mkIn(1, 3, 1, 2, 0),   mkOut(0, 0, 0, 0,   0, 1, 7));
    vecs[13] = mkVec(mkIn(1, 1, 1, 2, 0),   mkOut(1, 2, 0, 0,   1, 0, 0));
    vecs[14] = mkVec(mkIn(1, 2, 0, 0, 0),   mkOut(0, 0, 0, 0,   1, 0, 0));
    vecs[15] = mkVec(mkIn(1, 6, 0, 0, 0),   mkOut(0, 0, 0, 0,   0, 0, 6));
    vecs[16] = mkVec(mkIn(0, 0, 1, 0, 1),   mkOut(0, 0, 1, 6,   0, 0, 0));
    vecs[17] = mkVec(mkIn(0, 0, 0, 0, 1),   mkOut(0, 0, 0, 0,   0, 0, 0));
    vecs[18] = mkVec(mkIn(1, 0, 0, 0, 0),   mkOut(0, 0, 0, 0,   0, 0, 0));
    vecs[19] = mkVec(mkIn(1, 250, 0, 0, 0), mkOut(0, 0, 0, 0,   0, 0, 250));
    vecs[20] = mkVec(mkIn(1, 10, 0, 0, 0),  mkOut(0, 0, 0, 0,   1, 0, 250));
    vecs[21] = mkVec(mkIn(1, 5, 0, 0, 0),   mkOut(0, 0, 0, 0,   0, 0, 255));
    vecs[22] = mkVec(mkIn(1, 1, 0, 0, 0),   mkOut(0, 0, 0, 0,   1, 0, 255));
    vecs[23] = mkVec(mkIn(0, 0, 1, 3, 0),   mkOut(1, 3, 1, 245, 0, 0, 0));
    vecs[24] = mkVec(mkIn(0, 0, 1, 0, 0),   mkOut(0, 0, 0, 0,   0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_state", sampleA(), mkOut(0, 0, 0, 0, 0, 0, 0));
    rst_ni = 1'b1;
    tick();

    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i].stim, 1'b0);
      tick();
      checkOutput($sformatf("vec%0d", i), sampleA(), vecs[i].exp);
    end
    applyStimulus(mkIn(0, 0, 0, 0, 0), 1'b0);
    tick();

    // Out-of-range select on a three-item machine
    applyStimulus(mkIn(1, 10, 0, 0, 0), 1'b1);
    tick();
    checkOutput("b_coin10", sampleB(), mkOut(0, 0, 0, 0, 0, 0, 10));
    applyStimulus(mkIn(0, 0, 1, 3, 0), 1'b1);
    tick();
    checkOutput("b_sel3_oob", sampleB(), mkOut(0, 0, 0, 0, 0, 1, 10));
    applyStimulus(mkIn(0, 0, 1, 2, 0), 1'b1);
    tick();
    checkOutput("b_sel2", sampleB(), mkOut(1, 2, 1, 3, 0, 0, 0));
    applyStimulus(mkIn(0, 0, 0, 0, 0), 1'b1);
    tick();

    // Idle-credit timeout: refund lands exactly 16 cycles after the coin
    applyStimulus(mkIn(1, 2, 0, 0, 0), 1'b0);
    tick();
    applyStimulus(mkIn(0, 0, 0, 0, 0), 1'b0);
    checkOutput("to_coin", sampleA(), mkOut(0, 0, 0, 0, 0, 0, 2));
    for (int k = 1; k < 16; k++) begin
      tick();
      checkOutput($sformatf("to_wait%0d", k), sampleA(), mkOut(0, 0, 0, 0, 0, 0, 2));
    end
    tick();
    checkOutput("to_refund", sampleA(), mkOut(0, 0, 1, 2, 0, 0, 0));
    tick();
    checkOutput("to_after", sampleA(), mkOut(0, 0, 0, 0, 0, 0, 0));

    // Reset while a refund pulse is showing drops it at once
    applyStimulus(mkIn(1, 4, 0, 0, 0), 1'b0);
    tick();
    applyStimulus(mkIn(0, 0, 0, 0, 1), 1'b0);
    tick();
    applyStimulus(mkIn(0, 0, 0, 0, 0), 1'b0);
    checkOutput("rst_pend_pulse", sampleA(), mkOut(0, 0, 1, 4, 0, 0, 0));
    #2 rst_ni = 1'b0;
    #1 checkOutput("rst_pend_drop", sampleA(), mkOut(0, 0, 0, 0, 0, 0, 0));
    tick();
    rst_ni = 1'b1;
    tick();

    // Async reset mid-collect discards credit without a refund
    applyStimulus(mkIn(1, 7, 0, 0, 0), 1'b0);
    tick();
    applyStimulus(mkIn(0, 0, 0, 0, 0), 1'b0);
    checkOutput("rst_credit7", sampleA(), mkOut(0, 0, 0, 0, 0, 0, 7));
    #2 rst_ni = 1'b0;
    #1 checkOutput("rst_async", sampleA(), mkOut(0, 0, 0, 0, 0, 0, 0));
    tick();
    rst_ni = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      checkOutput($sformatf("rst_quiet%0d", k), sampleA(), mkOut(0, 0, 0, 0, 0, 0, 0));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
